// File: rtl/pdm_tx_pkg.sv
// Shared PDM-path constants, widths and the integrator saturation helper.
// Used by the transmitter today, meant to be reused by the CIC and audio clock blocks.
package pdm_tx_pkg;
    localparam int W      = 16;
    localparam int LOG2_R = 6;
    localparam int ACC_W  = W + 4;
    localparam int ACC_IW = W + LOG2_R + 1;
    localparam int SUM_W  = ACC_W + 2;

    localparam int SAT_MAX_I = (1 << (ACC_W - 1)) - 1;
    localparam logic signed [SUM_W-1:0] FS      = SUM_W'(1 << (W - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(SAT_MAX_I);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - 1;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] c;
        if (v > SAT_MAX)      c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        else                  c = v;
        return ACC_W'(c);
    endfunction
endpackage

// File: rtl/pdm_tx_sdm2.sv
// 2nd-order saturating sigma-delta modulator, one output bit per en strobe.
// Latency: x sampled on an en cycle shows up on pdm_out after that edge.
// Backpressure: none, state holds whenever en is low.
module pdm_sdm2
    import pdm_tx_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic                pdm_out
);
    logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                    pdm_q, pdm_d;
    logic signed [SUM_W-1:0] fb, s1, s2;

    // Sums are formed two bits wider than the integrators so the clamp sees the true value.
    always_comb begin
        fb    = pdm_q ? FS : -FS;
        s1    = SUM_W'(i1_q) + SUM_W'(x) - fb;
        i1_d  = sat_acc(s1);
        s2    = SUM_W'(i2_q) + SUM_W'(i1_d) - fb;
        i2_d  = sat_acc(s2);
        pdm_d = ~i2_d[ACC_W-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else if (en) begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_out = pdm_q;
endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: one-entry holding buffer, linear interpolator, 2nd-order SDM.
// Latency: a sample accepted before en_pcm k drives x from en_pcm k+1, pdm_out one en_pdm later.
// Backpressure: din_ready drops while the holding buffer is full; en_pcm on empty pulses underrun.
module pdm_tx
    import pdm_tx_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en_pdm,
    input  logic         en_pcm,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         pdm_out,
    output logic         underrun
);
    logic                     full_q, full_d;
    logic signed [W-1:0]      nb_q, nb_d;
    logic signed [W-1:0]      t_q, t_d;
    logic signed [W:0]        step_q, step_d, step_new;
    logic signed [ACC_IW-1:0] acc_q, acc_d, t_ext;
    logic                     under_q, under_d;
    logic signed [W-1:0]      x;

    always_comb begin
        step_new = (W+1)'(nb_q) - (W+1)'(t_q);
        t_ext    = ACC_IW'(t_q) <<< LOG2_R;
        full_d   = full_q;
        nb_d     = nb_q;
        t_d      = t_q;
        step_d   = step_q;
        acc_d    = acc_q;
        under_d  = 1'b0;
        if (en_pcm) begin
            // Restart each period from the exact previous target so rounding never accumulates.
            if (full_q) begin
                step_d = step_new;
                t_d    = nb_q;
                acc_d  = t_ext + (en_pdm ? ACC_IW'(step_new) : '0);
                full_d = 1'b0;
            end else begin
                under_d = 1'b1;
                step_d  = '0;
                acc_d   = t_ext;
                if (din_valid) begin
                    nb_d   = din;
                    full_d = 1'b1;
                end
            end
        end else begin
            if (en_pdm) acc_d = acc_q + ACC_IW'(step_q);
            if (din_valid && !full_q) begin
                nb_d   = din;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            nb_q    <= '0;
            t_q     <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            under_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            nb_q    <= nb_d;
            t_q     <= t_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            under_q <= under_d;
        end
    end

    assign x         = W'(acc_q >>> LOG2_R);
    assign din_ready = ~full_q;
    assign underrun  = under_q;

    pdm_sdm2 u_sdm (
        .clk     (clk),
        .reset   (reset),
        .en      (en_pdm),
        .x       (x),
        .pdm_out (pdm_out)
    );
endmodule
